// File: rtl/bcd_to_signed_bin_if.sv
// Handshake and data bundle for the signed-BCD to binary converter.
// The master drives the request and digits; the slave returns status and the result.
interface bcd_to_signed_bin_if #(
  parameter int BIN_W = 10
);
  logic             start;
  logic             sign_b;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] binary;
  logic             err;

  modport master (
    output start, sign_b, hundreds, tens, ones,
    input  busy, done, binary, err
  );

  modport slave (
    input  start, sign_b, hundreds, tens, ones,
    output busy, done, binary, err
  );
endinterface

// File: rtl/bcd_to_signed_bin.sv
// Sequential signed-BCD to two's-complement converter (reverse double-dabble).
// One shift per clock, BIN_W iterations, then range check and sign apply.
module bcd_to_signed_bin #(
  parameter int BIN_W = 10,
  parameter int N_DIG = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_to_signed_bin_if.slave  bus
);
  localparam int BCD_W = 4 * N_DIG;
  localparam logic [BIN_W-1:0] POS_MAX = {1'b0, {(BIN_W-1){1'b1}}};
  localparam logic [BIN_W-1:0] NEG_MAX = {1'b1, {(BIN_W-1){1'b0}}};
  localparam logic [3:0]       LAST_IT = 4'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               sign_q, sign_d;
  logic               bad_q, bad_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   binary_q, binary_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]       digits_in;
  logic [BCD_W+BIN_W-1:0] cat;
  logic [BCD_W-1:0]       bcd_adj;
  logic                   ovf;

  assign digits_in = {bus.hundreds, bus.tens, bus.ones};

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    sign_d   = sign_q;
    bad_d    = bad_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    binary_d = binary_q;
    err_d    = err_q;
    cat      = '0;
    bcd_adj  = '0;
    ovf      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd_d  = digits_in;
          sign_d = bus.sign_b;
          bin_d  = '0;
          cnt_d  = '0;
          bad_d  = 1'b0;
          for (int unsigned i = 0; i < N_DIG; i++) begin
            if (digits_in[4*i +: 4] > 4'd9) bad_d = 1'b1;
          end
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Shift the whole {bcd, bin} pair right, then undo the +3 bias
        // that a forward double-dabble would have added to each digit.
        cat     = {bcd_q, bin_q} >> 1;
        bcd_adj = cat[BCD_W+BIN_W-1 -: BCD_W];
        for (int unsigned i = 0; i < N_DIG; i++) begin
          if (bcd_adj[4*i +: 4] >= 4'd8) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
        end
        bcd_d = bcd_adj;
        bin_d = cat[BIN_W-1:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_IT) state_d = FINISH;
      end

      FINISH: begin
        ovf = sign_q ? (bin_q > NEG_MAX) : (bin_q > POS_MAX);
        if (bad_q || ovf) begin
          binary_d = '0;
          err_d    = 1'b1;
        end else begin
          binary_d = sign_q ? (~bin_q + 1'b1) : bin_q;
          err_d    = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      sign_q   <= 1'b0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      binary_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      sign_q   <= sign_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      binary_q <= binary_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.binary = binary_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_to_signed_bin.sv
// Randomized and directed bench for bcd_to_signed_bin against an arithmetic
// reference model of signed decimal to 10-bit two's complement.
module tb_bcd_to_signed_bin;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  bcd_to_signed_bin_if #(.BIN_W(10)) bus ();

  bcd_to_signed_bin #(.BIN_W(10), .N_DIG(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal value with sign, legal range -512..511, digits 0..9.
  function automatic logic [10:0] ref_conv(input bit s, input int h, input int t, input int o);
    int mag;
    int v;
    mag = h * 100 + t * 10 + o;
    v   = s ? -mag : mag;
    if (h > 9 || t > 9 || o > 9 || v < -512 || v > 511) return {1'b1, 10'd0};
    return {1'b0, v[9:0]};
  endfunction

  task automatic run_conv(input bit s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input logic [9:0] eb, input bit ee, input string tag);
    int lat;
    int bcnt;
    bit overlap;
    @(negedge clk);
    bus.sign_b = s; bus.hundreds = h; bus.tens = t; bus.ones = o; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sign_b = ~s; bus.hundreds = 4'($urandom); bus.tens = 4'($urandom); bus.ones = 4'($urandom);
    bcnt = int'(bus.busy);
    lat = 0;
    overlap = 1'b0;
    while (!bus.done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) bcnt++;
      if (bus.busy && bus.done) overlap = 1'b1;
    end
    check_eq({tag, "_latency"}, lat, 11);
    check_eq({tag, "_busy_cycles"}, bcnt, 11);
    check_eq({tag, "_busy_done_overlap"}, 32'(overlap), 0);
    check_eq({tag, "_binary"}, 32'(bus.binary), 32'(eb));
    check_eq({tag, "_err"}, 32'(bus.err), 32'(ee));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  task automatic run_model(input bit s, input int h, input int t, input int o, input string tag);
    logic [10:0] r;
    r = ref_conv(s, h, t, o);
    run_conv(s, 4'(h), 4'(t), 4'(o), r[9:0], r[10], tag);
  endtask

  initial begin
    int ndone;
    int v, mag;
    logic [10:0] r;
    bus.start = 1'b0; bus.sign_b = 1'b0; bus.hundreds = '0; bus.tens = '0; bus.ones = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'(bus.busy), 0);
    check_eq("reset_done", 32'(bus.done), 0);
    check_eq("reset_binary", 32'(bus.binary), 0);
    check_eq("reset_err", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived expectations
    run_conv(1'b0, 4'd1, 4'd2, 4'd3, 10'h07B, 1'b0, "pos123");
    run_conv(1'b1, 4'd0, 4'd0, 4'd5, 10'h3FB, 1'b0, "neg5");
    run_conv(1'b1, 4'd5, 4'd1, 4'd2, 10'h200, 1'b0, "neg512");
    run_conv(1'b0, 4'd5, 4'd1, 4'd2, 10'h000, 1'b1, "pos512_ovf");
    run_conv(1'b1, 4'd9, 4'd9, 4'd9, 10'h000, 1'b1, "neg999_ovf");
    run_conv(1'b0, 4'd0, 4'hA, 4'd3, 10'h000, 1'b1, "bad_digit");
    run_conv(1'b1, 4'd0, 4'd0, 4'd0, 10'h000, 1'b0, "neg_zero");
    run_conv(1'b0, 4'd5, 4'd1, 4'd1, 10'h1FF, 1'b0, "pos511");

    // Start pulse mid-conversion must be ignored
    @(negedge clk);
    bus.sign_b = 1'b0; bus.hundreds = 4'd0; bus.tens = 4'd4; bus.ones = 4'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hundreds = 4'd3;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        check_eq("mid_start_binary", 32'(bus.binary), 32'd42);
      end
    end
    check_eq("mid_start_done_count", ndone, 1);

    // Start held high: back-to-back conversions over 36 edges
    @(negedge clk);
    bus.sign_b = 1'b1; bus.hundreds = 4'd0; bus.tens = 4'd1; bus.ones = 4'd7; bus.start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        check_eq("b2b_binary", 32'(bus.binary), 32'(10'h3EF));
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_done_count", ndone, 3);
    repeat (15) @(posedge clk);

    // Reset during shift cycle 5 aborts with no done
    @(negedge clk);
    bus.sign_b = 1'b0; bus.hundreds = 4'd3; bus.tens = 4'd0; bus.ones = 4'd0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_done", 32'(bus.done), 0);
    check_eq("abort_binary", 32'(bus.binary), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) ndone++;
    end
    check_eq("abort_no_activity", ndone, 0);

    // Randomized against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      int h, t, o;
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      o = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      run_model(1'($urandom), h, t, o, "rand");
    end

    // Round trip over the whole representable range
    for (int vv = -512; vv <= 511; vv++) begin
      v   = vv;
      mag = (v < 0) ? -v : v;
      r   = 11'(v);
      run_conv(v < 0, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10), r[9:0], 1'b0, "roundtrip");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
